// File: rtl/adder_pkg.sv
// Shared types and operand-encoding helpers for the pipelined adder.
package adder_pkg;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_ADD1  = 2'b01,
        OP_SUB   = 2'b10,
        OP_SUBM1 = 2'b11
    } op_t;

    // Widest operand eff_b can handle; callers zero-extend into this width.
    localparam int unsigned MAX_WIDTH = 128;

    function automatic logic carry_in(op_t op);
        return (op == OP_ADD1) || (op == OP_SUB);
    endfunction

    function automatic logic [MAX_WIDTH-1:0] eff_b(op_t op, logic [MAX_WIDTH-1:0] b);
        return ((op == OP_SUB) || (op == OP_SUBM1)) ? ~b : b;
    endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle between a producer and the pipelined adder.
interface pipelined_adder_if
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    op_t              op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;
    logic             zero;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, sum, cout, overflow, zero
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, sum, cout, overflow, zero
    );
endinterface

// File: rtl/adder_segment.sv
// SEG-bit ripple-carry segment; also exposes the carry into its top bit for overflow.
module adder_segment #(
    parameter int unsigned SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout,
    output logic           cmsb
);
    always_comb begin
        logic c;
        c    = cin;
        s    = '0;
        cmsb = 1'b0;
        for (int unsigned i = 0; i < SEG; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            if (i == SEG - 1) cmsb = c;
            c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: STAGES carry-chained segments with valid/ready on both sides
// and a synchronous flush.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    pipelined_adder_if.slave  bus
);
    localparam int unsigned SEG = WIDTH / STAGES;

    logic [STAGES-1:0]             v_q, v_d, adv;
    logic [STAGES-1:0][WIDTH-1:0]  s_q, s_d, a_q, a_d, b_q, b_d;
    logic [STAGES-1:0]             c_q, c_d;
    logic                          ovf_q, ovf_d, zero_q, zero_d;

    logic [STAGES-1:0][WIDTH-1:0]  src_a, src_b, src_s;
    logic [STAGES-1:0]             src_c;
    logic [STAGES-1:0][SEG-1:0]    seg_sum;
    logic [STAGES-1:0]             seg_cout, seg_cmsb;
    logic [MAX_WIDTH-1:0]          b_ext, b_eff;
    logic                          accept;
    logic                          unused_bits;

    // Stall chain: a stage moves when it is empty or its successor moves.
    always_comb begin
        adv = '0;
        for (int unsigned k = STAGES; k > 0; k--) begin
            if (k == STAGES) adv[k-1] = !v_q[k-1] || bus.out_ready;
            else             adv[k-1] = !v_q[k-1] || adv[k];
        end
    end

    assign bus.in_ready = adv[0] && !flush;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        b_ext             = '0;
        b_ext[WIDTH-1:0]  = bus.b;
        b_eff             = eff_b(bus.op, b_ext);
        src_a             = '0;
        src_b             = '0;
        src_s             = '0;
        src_c             = '0;
        src_a[0]          = bus.a;
        src_b[0]          = b_eff[WIDTH-1:0];
        src_c[0]          = carry_in(bus.op);
        for (int unsigned k = 1; k < STAGES; k++) begin
            src_a[k] = a_q[k-1];
            src_b[k] = b_q[k-1];
            src_s[k] = s_q[k-1];
            src_c[k] = c_q[k-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_seg
        adder_segment #(.SEG(SEG)) u_seg (
            .a    (src_a[g][g*SEG +: SEG]),
            .b    (src_b[g][g*SEG +: SEG]),
            .cin  (src_c[g]),
            .s    (seg_sum[g]),
            .cout (seg_cout[g]),
            .cmsb (seg_cmsb[g])
        );
    end

    // Data registers only load on advance, so a stalled output stays stable.
    always_comb begin
        v_d    = v_q;
        s_d    = s_q;
        a_d    = a_q;
        b_d    = b_q;
        c_d    = c_q;
        ovf_d  = ovf_q;
        zero_d = zero_q;
        for (int unsigned k = 0; k < STAGES; k++) begin
            if (adv[k]) begin
                if (k == 0) v_d[k] = accept;
                else        v_d[k] = v_q[k-1];
                s_d[k]                 = src_s[k];
                s_d[k][k*SEG +: SEG]   = seg_sum[k];
                a_d[k]                 = src_a[k];
                b_d[k]                 = src_b[k];
                c_d[k]                 = seg_cout[k];
            end
        end
        if (adv[STAGES-1]) begin
            ovf_d  = seg_cmsb[STAGES-1] ^ seg_cout[STAGES-1];
            zero_d = (s_d[STAGES-1] == '0);
        end
        if (flush) v_d = '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v_q    <= '0;
            s_q    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            v_q    <= v_d;
            s_q    <= s_d;
            a_q    <= a_d;
            b_q    <= b_d;
            c_q    <= c_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign bus.out_valid = v_q[STAGES-1];
    assign bus.sum       = s_q[STAGES-1];
    assign bus.cout      = c_q[STAGES-1];
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;

    // Consumed low operand bits and the last stage's operand copies are dead by design.
    assign unused_bits = ^{a_q, b_q, b_eff};

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder (WIDTH=32, STAGES=4) with directed vectors.
module tb_pipelined_adder;
    import adder_pkg::*;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned STAGES = 4;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        op_t         op;
        logic [31:0] s;
        logic        c;
        logic        o;
        logic        z;
    } vec_t;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic flush   = 1'b0;

    always #5 clk = ~clk;

    pipelined_adder_if #(.WIDTH(WIDTH)) bus ();

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus)
    );

    exp_t        q[$];
    exp_t        e;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc   = 0;
    int          n_out = 0;
    int          base;
    bit          saw_bp = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_sum;

    vec_t basic[5] = '{
        '{32'd1234,       32'd0, OP_ADD1,  32'd1235,       1'b0, 1'b0, 1'b0},
        '{32'hFFFF_FFFF,  32'd0, OP_ADD1,  32'd0,          1'b1, 1'b0, 1'b1},
        '{32'h7FFF_FFFF,  32'd1, OP_ADD,   32'h8000_0000,  1'b0, 1'b1, 1'b0},
        '{32'd5,          32'd7, OP_SUB,   32'hFFFF_FFFE,  1'b0, 1'b0, 1'b0},
        '{32'd7,          32'd5, OP_SUBM1, 32'd1,          1'b1, 1'b0, 1'b0}
    };

    vec_t burst[8] = '{
        '{32'd100,        32'd23,         OP_ADD,   32'd123,        1'b0, 1'b0, 1'b0},
        '{32'd100,        32'd23,         OP_ADD1,  32'd124,        1'b0, 1'b0, 1'b0},
        '{32'd100,        32'd23,         OP_SUB,   32'd77,         1'b1, 1'b0, 1'b0},
        '{32'd100,        32'd23,         OP_SUBM1, 32'd76,         1'b1, 1'b0, 1'b0},
        '{32'd0,          32'd0,          OP_ADD,   32'd0,          1'b0, 1'b0, 1'b1},
        '{32'd0,          32'd1,          OP_SUB,   32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0},
        '{32'h8000_0000,  32'd1,          OP_SUB,   32'h7FFF_FFFF,  1'b1, 1'b1, 1'b0},
        '{32'h1234_5678,  32'h1111_1111,  OP_ADD,   32'h2345_6789,  1'b0, 1'b0, 1'b0}
    };

    vec_t flushed[3] = '{
        '{32'd1, 32'd1, OP_ADD, 32'd2, 1'b0, 1'b0, 1'b0},
        '{32'd2, 32'd2, OP_ADD, 32'd4, 1'b0, 1'b0, 1'b0},
        '{32'd3, 32'd3, OP_ADD, 32'd6, 1'b0, 1'b0, 1'b0}
    };

    vec_t inflight[4] = '{
        '{32'd1234, 32'd0, OP_ADD1, 32'd1235, 1'b0, 1'b0, 1'b0},
        '{32'd1,    32'd2, OP_ADD,  32'd3,    1'b0, 1'b0, 1'b0},
        '{32'd3,    32'd4, OP_ADD,  32'd7,    1'b0, 1'b0, 1'b0},
        '{32'd9,    32'd1, OP_SUB,  32'd8,    1'b1, 1'b0, 1'b0}
    };

    vec_t after_flush = '{32'd10, 32'd20, OP_ADD, 32'd30, 1'b0, 1'b0, 1'b0};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops one expectation per output transfer.
    always @(negedge clk) begin
        if (reset_n) begin
            if (prev_stall) begin
                chk("stall_hold_valid", bus.out_valid, 1);
                chk("stall_hold_sum", bus.sum, prev_sum);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", bus.out_valid, 0);
                end else begin
                    e = q.pop_front();
                    chk("sum", bus.sum, e.sum);
                    chk("cout", bus.cout, e.cout);
                    chk("overflow", bus.overflow, e.ovf);
                    chk("zero", bus.zero, e.zero);
                    if (e.chk_lat) chk("latency", cyc - e.acc_cyc, STAGES);
                    n_out++;
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_sum   = bus.sum;
        end else begin
            prev_stall = 0;
        end
    end

    task automatic drive(vec_t v, bit lat);
        bit acc;
        int ac;
        bus.a        = v.a;
        bus.b        = v.b;
        bus.op       = v.op;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            acc = bus.in_ready;
            ac  = cyc;
            if (!acc) saw_bp = 1;
            @(posedge clk);
            if (acc) begin
                q.push_back('{v.s, v.c, v.o, v.z, ac, lat});
                #1;
                bus.in_valid = 1'b0;
                return;
            end
            #1;
        end
        n_cmp++;
        n_err++;
        $display("FAIL accept_timeout: in_ready stayed 0 for 50 cycles (required 1)");
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 60; t++) begin
            @(posedge clk);
            if (q.size() == 0) break;
        end
        chk("drain_empty", q.size(), 0);
        #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = OP_ADD;
        bus.out_ready = 1'b1;

        #2;
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_sum", bus.sum, 0);
        chk("reset_cout", bus.cout, 0);
        chk("reset_overflow", bus.overflow, 0);
        chk("reset_zero", bus.zero, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        #1 chk("in_ready_after_reset", bus.in_ready, 1);
        @(posedge clk);
        #1;

        foreach (basic[i]) begin
            drive(basic[i], 1'b1);
            wait_drain();
        end

        // Eight back-to-back ops with the consumer stalled for cycles 5..9.
        saw_bp = 0;
        base   = n_out;
        fork
            begin
                foreach (burst[i]) drive(burst[i], 1'b0);
            end
            begin
                for (int c = 0; c < 16; c++) begin
                    bus.out_ready = !(c >= 5 && c <= 9);
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        wait_drain();
        chk("backpressure_seen", saw_bp, 1);
        chk("burst_count", n_out - base, 8);

        // Flush with three ops in flight and a fourth presented.
        base = n_out;
        foreach (flushed[i]) drive(flushed[i], 1'b0);
        bus.a        = 32'd99;
        bus.b        = 32'd1;
        bus.op       = OP_ADD;
        bus.in_valid = 1'b1;
        flush        = 1'b1;
        @(negedge clk);
        chk("in_ready_during_flush", bus.in_ready, 0);
        @(posedge clk);
        q.delete();
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("out_valid_after_flush", bus.out_valid, 0);
        repeat (6) @(posedge clk);
        #1;
        chk("flushed_never_out", n_out - base, 0);
        drive(after_flush, 1'b1);
        wait_drain();
        chk("post_flush_count", n_out - base, 1);

        // Asynchronous reset with a full, stalled pipeline.
        bus.out_ready = 1'b0;
        foreach (inflight[i]) drive(inflight[i], 1'b0);
        #1;
        chk("out_valid_before_reset", bus.out_valid, 1);
        chk("sum_before_reset", bus.sum, 32'd1235);
        #1 reset_n = 1'b0;
        #1;
        chk("async_reset_out_valid", bus.out_valid, 0);
        chk("async_reset_sum", bus.sum, 0);
        q.delete();
        base = n_out;
        @(posedge clk);
        #1 reset_n   = 1'b1;
        bus.out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("no_output_after_reset", bus.out_valid, 0);
        chk("no_results_after_reset", n_out - base, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (required completion)");
        $fatal(1);
    end

endmodule
